// File: rtl/float_pkg.sv
// Shared FP16 field layout, Q-format constants and FSM encoding for the
// half-precision to fixed-point converter.
package float_pkg;

  localparam int FP_W          = 16;
  localparam int EXP_W         = 5;
  localparam int MANT_W        = 10;
  localparam int MAG_W         = MANT_W + 1;
  localparam int EXP_BIAS      = 15;
  localparam int FRAC_BITS_DEF = 16;
  localparam int OVF_EXP       = 30;
  localparam int FIX_W         = 32;
  // Largest in-range left shift is 20 (exponent 29), so the counter needs 5 bits.
  localparam int CNT_W         = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic [FIX_W-1:0] apply_sign(input logic neg,
                                                  input logic [FIX_W-1:0] mag);
    return neg ? -mag : mag;
  endfunction

endpackage

// File: rtl/fp16_unpack.sv
// Combinational FP16 field unpack: sign, magnitude with hidden bit, shift
// direction/amount and overflow value. FLOAT_CONV_SATURATE_EN selects saturation.
module fp16_unpack
  import float_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic [FP_W-1:0]  fp_in,
  output logic             sign,
  output logic [MAG_W-1:0] mag,
  output logic             left,
  output logic [CNT_W-1:0] amt,
  output logic             ovf,
  output logic [FIX_W-1:0] ovf_val
);

  logic [EXP_W-1:0]  exp_f;
  logic [MANT_W-1:0] mant;
  int                e_eff;
  int                shift;

  always_comb begin
    sign  = fp_in[FP_W-1];
    exp_f = fp_in[FP_W-2 -: EXP_W];
    mant  = fp_in[MANT_W-1:0];
    mag   = {(exp_f != '0), mant};
    // Denormals share the scale of exponent 1.
    e_eff = (exp_f == '0) ? 1 : int'(exp_f);
    shift = e_eff - (EXP_BIAS + MANT_W) + FRAC_BITS;
    left  = (shift > 0);
    amt   = CNT_W'((shift < 0) ? -shift : shift);
    ovf   = (int'(exp_f) >= OVF_EXP);
`ifdef FLOAT_CONV_SATURATE_EN
    // NaN always saturates positive, regardless of its sign bit.
    ovf_val = (sign && !(exp_f == '1 && mant != '0)) ? {1'b1, {(FIX_W-1){1'b0}}}
                                                     : {1'b0, {(FIX_W-1){1'b1}}};
`else
    ovf_val = '0;
`endif
  end

endmodule

// File: rtl/float_to_fixed.sv
// FP16 to signed fixed-point converter: serial one-bit-per-cycle shifter with
// valid/ready handshakes. Overflow saturation is enabled by FLOAT_CONV_SATURATE_EN.
module float_to_fixed
  import float_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [FP_W-1:0]  floatIn,
  input  logic             inValid,
  output logic             inReady,
  output logic [FIX_W-1:0] fixedOut,
  output logic             outValid,
  input  logic             outReady,
  output logic             overflow
);

  logic             u_sign, u_left, u_ovf;
  logic [MAG_W-1:0] u_mag;
  logic [CNT_W-1:0] u_amt;
  logic [FIX_W-1:0] u_ovf_val;

  fp16_unpack #(.FRAC_BITS(FRAC_BITS)) u_unpack (
    .fp_in   (floatIn),
    .sign    (u_sign),
    .mag     (u_mag),
    .left    (u_left),
    .amt     (u_amt),
    .ovf     (u_ovf),
    .ovf_val (u_ovf_val)
  );

  state_e           state_q, state_d;
  logic [FIX_W-1:0] mag_q, mag_d, fixed_q, fixed_d, shifted;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             left_q, left_d, sign_q, sign_d, ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d, in_ready_q, in_ready_d;

  always_comb begin
    // NOTE: every output starts from its held value, so no path can infer a latch.
    state_d     = state_q;
    mag_d       = mag_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    sign_d      = sign_q;
    ovf_d       = ovf_q;
    fixed_d     = fixed_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    shifted     = left_q ? (mag_q << 1) : (mag_q >> 1);

    unique case (state_q)
      ST_IDLE: begin
        if (inValid) begin
          sign_d     = u_sign;
          left_d     = u_left;
          mag_d      = FIX_W'(u_mag);
          cnt_d      = u_amt;
          ovf_d      = u_ovf;
          in_ready_d = 1'b0;
          if (u_ovf) begin
            state_d     = ST_DONE;
            fixed_d     = u_ovf_val;
            out_valid_d = 1'b1;
          end else if (u_amt == '0) begin
            state_d     = ST_DONE;
            fixed_d     = apply_sign(u_sign, FIX_W'(u_mag));
            out_valid_d = 1'b1;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        mag_d = shifted;
        cnt_d = cnt_q - CNT_W'(1);
        // The final shift and the result load share one edge to meet |s|+1 latency.
        if (cnt_q == CNT_W'(1)) begin
          state_d     = ST_DONE;
          fixed_d     = apply_sign(sign_q, shifted);
          out_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (outReady) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= ST_IDLE;
      mag_q       <= '0;
      cnt_q       <= '0;
      left_q      <= 1'b0;
      sign_q      <= 1'b0;
      ovf_q       <= 1'b0;
      fixed_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      sign_q      <= sign_d;
      ovf_q       <= ovf_d;
      fixed_q     <= fixed_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign inReady  = in_ready_q;
  assign fixedOut = fixed_q;
  assign outValid = out_valid_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_float_to_fixed.sv
// Scoreboard bench for float_to_fixed: real-arithmetic reference model, random
// and directed FP16 stimulus, random back-pressure, stall and mid-conversion reset.
module tb_float_to_fixed;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [15:0] floatIn = '0;
  logic        inValid = 1'b0;
  logic        outReady = 1'b0;
  logic        inReady, outValid, overflow;
  logic [31:0] fixedOut;

  float_to_fixed dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .floatIn  (floatIn),
    .inValid  (inValid),
    .inReady  (inReady),
    .fixedOut (fixedOut),
    .outValid (outValid),
    .outReady (outReady),
    .overflow (overflow)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] f;
    logic [31:0] fx;
    logic        ov;
    int          lat;
    int          acc_cycle;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cycle = 0;
  int   stall_req = 0;

  always @(posedge Clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: value = (-1)^s * m * 2^(e-25), scaled by 2^16, truncated toward zero.
  function automatic exp_t model(input logic [15:0] f);
    exp_t r;
    int   ex, mt, e, m, s, iv;
    real  v;
    ex = int'(f[14:10]);
    mt = int'(f[9:0]);
    e  = (ex == 0) ? 1 : ex;
    m  = ((ex != 0) ? 1024 : 0) + mt;
    s  = e - 25 + 16;
    r.f = f;
    r.acc_cycle = 0;
    if (ex >= 30) begin
      r.ov  = 1'b1;
      r.lat = 1;
`ifdef FLOAT_CONV_SATURATE_EN
      if (ex == 31 && mt != 0) r.fx = 32'h7FFF_FFFF;
      else                     r.fx = f[15] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
      r.fx = 32'h0000_0000;
`endif
    end else begin
      r.ov  = 1'b0;
      r.lat = ((s < 0) ? -s : s) + 1;
      v     = real'(m) * (2.0 ** s);
      iv    = $rtoi(v);
      r.fx  = f[15] ? 32'(-iv) : 32'(iv);
    end
    return r;
  endfunction

  task automatic send(input logic [15:0] f);
    exp_t e;
    int   t;
    @(negedge Clk);
    floatIn = f;
    inValid = 1'b1;
    t = 0;
    while (!inReady && t < 200) begin
      @(negedge Clk);
      t++;
    end
    if (!inReady) begin
      fail_now("accept_timeout");
      inValid = 1'b0;
      return;
    end
    e = model(f);
    e.acc_cycle = cycle;
    sb.push_back(e);
    @(posedge Clk);
    #1 inValid = 1'b0;
  endtask

  // Monitor: owns outReady, pops the scoreboard on each new result.
  logic holding = 1'b0;
  logic hs_pending = 1'b0;
  int   stall_used = 0;
  exp_t cur;

  always @(negedge Clk) begin
    if (!Rst) begin
      holding    = 1'b0;
      hs_pending = 1'b0;
      outReady   = 1'b0;
    end else begin
      if (hs_pending) begin
        check("idle_after_hs_valid", 32'(outValid), 32'd0);
        check("idle_after_hs_ready", 32'(inReady), 32'd1);
        hs_pending = 1'b0;
      end
      if (outValid) begin
        check("in_ready_low_in_done", 32'(inReady), 32'd0);
        if (!holding) begin
          if (sb.size() == 0) begin
            fail_now("unexpected_out_valid");
            cur.fx = fixedOut;
            cur.ov = overflow;
          end else begin
            cur = sb.pop_front();
            check($sformatf("fixed[%h]", cur.f), fixedOut, cur.fx);
            check($sformatf("ovf[%h]", cur.f), 32'(overflow), 32'(cur.ov));
            check($sformatf("latency[%h]", cur.f), 32'(cycle - cur.acc_cycle), 32'(cur.lat));
          end
          holding = 1'b1;
        end else begin
          check("hold_fixed", fixedOut, cur.fx);
          check("hold_ovf", 32'(overflow), 32'(cur.ov));
        end
        if (stall_used < stall_req) begin
          outReady = 1'b0;
          stall_used++;
        end else begin
          outReady = ($urandom_range(0, 3) != 0);
        end
        if (outReady) begin
          holding    = 1'b0;
          hs_pending = 1'b1;
        end
      end else begin
        outReady = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || holding || outValid) && t < 500) begin
      @(negedge Clk);
      #1;
      t++;
    end
    if (t >= 500) fail_now("drain_timeout");
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) @(negedge Clk);
  endtask

  logic [15:0] directed [12] = '{16'h3C00, 16'hC100, 16'h2400, 16'h0400, 16'h0001, 16'h8000,
                                 16'h7800, 16'hFC00, 16'h7C01, 16'h77FF, 16'hF7FF, 16'h03FF};

  initial begin
    logic [15:0] f;
    #3 Rst = 1'b0;
    #2;
    check("rst_fixed", fixedOut, 32'd0);
    check("rst_valid", 32'(outValid), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    check("ready_after_reset", 32'(inReady), 32'd1);

    foreach (directed[i]) begin
      send(directed[i]);
      gap();
    end
    drain();

    // Stall in DONE for 5 cycles with inValid pulses that must be ignored.
    stall_req = stall_req + 5;
    send(16'h3C00);
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      floatIn = 16'($urandom);
      inValid = !inReady && (i % 2 == 0);
    end
    inValid = 1'b0;
    drain();

    // Reset in the middle of a SHIFT sequence discards the conversion.
    send(16'h3C00);
    repeat (2) @(negedge Clk);
    #2 Rst = 1'b0;
    #1;
    check("midreset_fixed", fixedOut, 32'd0);
    check("midreset_valid", 32'(outValid), 32'd0);
    check("midreset_ovf", 32'(overflow), 32'd0);
    sb.delete();
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    check("ready_after_midreset", 32'(inReady), 32'd1);
    repeat (20) @(negedge Clk);
    send(16'h3C00);
    drain();

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 2))
        0:       f = 16'($urandom);
        1:       f = {1'($urandom), 5'($urandom_range(0, 16)), 10'($urandom)};
        default: f = {1'($urandom), 5'($urandom_range(27, 31)), 10'($urandom)};
      endcase
      send(f);
      gap();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
